// File: rtl/alu_ex_pkg.sv
// Shared defines for the ALU execute slice: bus widths, opcode encodings and idle bus values.
package alu_ex_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 5;
    localparam int NAME_W = 5;
    localparam int OP_W   = 5;

    localparam logic [TAG_W-1:0]  TAG_FREE  = '0;
    localparam logic [NAME_W-1:0] NAME_FREE = '0;
    localparam logic [DATA_W-1:0] DATA_FREE = '0;

    localparam logic [OP_W-1:0] OP_NOP   = 5'd0;
    localparam logic [OP_W-1:0] OP_ADD   = 5'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 5'd2;
    localparam logic [OP_W-1:0] OP_AND   = 5'd3;
    localparam logic [OP_W-1:0] OP_OR    = 5'd4;
    localparam logic [OP_W-1:0] OP_XOR   = 5'd5;
    localparam logic [OP_W-1:0] OP_SLL   = 5'd6;
    localparam logic [OP_W-1:0] OP_SRL   = 5'd7;
    localparam logic [OP_W-1:0] OP_SRA   = 5'd8;
    localparam logic [OP_W-1:0] OP_SLT   = 5'd9;
    localparam logic [OP_W-1:0] OP_SLTU  = 5'd10;
    localparam logic [OP_W-1:0] OP_LUI   = 5'd11;
    localparam logic [OP_W-1:0] OP_AUIPC = 5'd12;
    localparam logic [OP_W-1:0] OP_JAL   = 5'd13;
    localparam logic [OP_W-1:0] OP_JALR  = 5'd14;

    function automatic logic is_work(input logic [OP_W-1:0] op);
        return op != OP_NOP;
    endfunction
endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath; unknown opcodes yield zero so the tag still gets released.
module alu_core
    import alu_ex_pkg::*;
#(
    parameter int LINK_OFFSET = 4
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [DATA_W-1:0] o_res
);
    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_res = DATA_FREE;
        case (i_op)
            OP_ADD:   o_res = i_a + i_b;
            OP_SUB:   o_res = i_a - i_b;
            OP_AND:   o_res = i_a & i_b;
            OP_OR:    o_res = i_a | i_b;
            OP_XOR:   o_res = i_a ^ i_b;
            OP_SLL:   o_res = i_a << w_shamt;
            OP_SRL:   o_res = i_a >> w_shamt;
            OP_SRA:   o_res = $signed(i_a) >>> w_shamt;
            OP_SLT:   o_res = {31'b0, $signed(i_a) < $signed(i_b)};
            OP_SLTU:  o_res = {31'b0, i_a < i_b};
            OP_LUI:   o_res = i_b;
            OP_AUIPC: o_res = i_pc + i_b;
            OP_JAL,
            OP_JALR:  o_res = i_pc + ADDR_W'(LINK_OFFSET);
            default:  o_res = DATA_FREE;
        endcase
    end
endmodule

// File: rtl/alu_ex.sv
// ALU execute stage with registered broadcast. Define ALU_PIPE2_EN for a second
// register stage (latency 2, still one op per cycle).
module alu_ex
    import alu_ex_pkg::*;
#(
    parameter int LINK_OFFSET = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ALUworkEn,
    input  logic [DATA_W-1:0] operandO,
    input  logic [DATA_W-1:0] operandT,
    input  logic [OP_W-1:0]   opCode,
    input  logic [TAG_W-1:0]  wrtTag,
    input  logic [NAME_W-1:0] wrtName,
    input  logic [ADDR_W-1:0] instAddr,
    output logic              enALUwrt,
    output logic [TAG_W-1:0]  ALUtag,
    output logic [DATA_W-1:0] ALUdata,
    output logic [NAME_W-1:0] ALUname
);
    logic              w_accept;
    logic [DATA_W-1:0] w_res;

    logic              r_s1_vld;
    logic [TAG_W-1:0]  r_s1_tag;
    logic [NAME_W-1:0] r_s1_name;
    logic [DATA_W-1:0] r_s1_data;

    assign w_accept = ALUworkEn && is_work(opCode);

    alu_core #(.LINK_OFFSET(LINK_OFFSET)) u_core (
        .i_op  (opCode),
        .i_a   (operandO),
        .i_b   (operandT),
        .i_pc  (instAddr),
        .o_res (w_res)
    );

    // Idle slots carry the free values so later stages can copy without muxing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_tag  <= TAG_FREE;
            r_s1_name <= NAME_FREE;
            r_s1_data <= DATA_FREE;
        end else if (rdy) begin
            r_s1_vld  <= w_accept;
            r_s1_tag  <= w_accept ? wrtTag  : TAG_FREE;
            r_s1_name <= w_accept ? wrtName : NAME_FREE;
            r_s1_data <= w_accept ? w_res   : DATA_FREE;
        end
    end

`ifdef ALU_PIPE2_EN
    logic              r_s2_vld;
    logic [TAG_W-1:0]  r_s2_tag;
    logic [NAME_W-1:0] r_s2_name;
    logic [DATA_W-1:0] r_s2_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_tag  <= TAG_FREE;
            r_s2_name <= NAME_FREE;
            r_s2_data <= DATA_FREE;
        end else if (rdy) begin
            r_s2_vld  <= r_s1_vld;
            r_s2_tag  <= r_s1_tag;
            r_s2_name <= r_s1_name;
            r_s2_data <= r_s1_data;
        end
    end

    assign enALUwrt = r_s2_vld;
    assign ALUtag   = r_s2_tag;
    assign ALUname  = r_s2_name;
    assign ALUdata  = r_s2_data;
`else
    assign enALUwrt = r_s1_vld;
    assign ALUtag   = r_s1_tag;
    assign ALUname  = r_s1_name;
    assign ALUdata  = r_s1_data;
`endif
endmodule

// File: tb/tb_alu_ex.sv
// Directed self-checking bench for alu_ex; expectations follow ALU_PIPE2_EN latency.
module tb_alu_ex;
    import alu_ex_pkg::*;

`ifdef ALU_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rdy = 1'b1;
    logic              ALUworkEn = 1'b0;
    logic [DATA_W-1:0] operandO = '0;
    logic [DATA_W-1:0] operandT = '0;
    logic [OP_W-1:0]   opCode = OP_NOP;
    logic [TAG_W-1:0]  wrtTag = '0;
    logic [NAME_W-1:0] wrtName = '0;
    logic [ADDR_W-1:0] instAddr = '0;
    logic              enALUwrt;
    logic [TAG_W-1:0]  ALUtag;
    logic [DATA_W-1:0] ALUdata;
    logic [NAME_W-1:0] ALUname;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_ex #(.LINK_OFFSET(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .ALUworkEn(ALUworkEn),
        .operandO(operandO), .operandT(operandT), .opCode(opCode),
        .wrtTag(wrtTag), .wrtName(wrtName), .instAddr(instAddr),
        .enALUwrt(enALUwrt), .ALUtag(ALUtag), .ALUdata(ALUdata), .ALUname(ALUname)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ALUworkEn = 1'b0;
        opCode    = OP_NOP;
        operandO  = '0;
        operandT  = '0;
        wrtTag    = '0;
        wrtName   = '0;
    endtask

    task automatic drive_op(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t, input logic [NAME_W-1:0] n, input logic [31:0] pc);
        ALUworkEn = 1'b1;
        opCode    = op;
        operandO  = a;
        operandT  = b;
        wrtTag    = t;
        wrtName   = n;
        instAddr  = pc;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (enALUwrt !== 1'b0 || ALUtag !== TAG_FREE || ALUname !== NAME_FREE || ALUdata !== DATA_FREE) begin
            failures++;
            $display("FAIL reset_state: en=%b tag=%h name=%h data=%h, want 0/%h/%h/%h",
                     enALUwrt, ALUtag, ALUname, ALUdata, TAG_FREE, NAME_FREE, DATA_FREE);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (enALUwrt !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: en=%b want 0", enALUwrt);
        end
    endtask

    task automatic test_ops();
        logic [OP_W-1:0] ops [15] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
                                      OP_SLT, OP_SLTU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, 5'd31};
        logic [31:0] av [15] = '{32'hFFFFFFFF, 32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000,
                                 32'h1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h5};
        logic [31:0] bv [15] = '{32'h2, 32'h7, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F,
                                 32'h21, 32'h24, 32'h24, 32'h1, 32'h1,
                                 32'h12345000, 32'h2000, 32'h0, 32'h0, 32'h5};
        logic [31:0] pcv [15] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000,
                                  32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000,
                                  32'h1000, 32'h2000, 32'h1000};
        logic [31:0] ev [15] = '{32'h00000001, 32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F,
                                 32'h00000002, 32'h08000000, 32'hF8000000, 32'h00000001, 32'h00000000,
                                 32'h12345000, 32'h00003000, 32'h00001004, 32'h00002004, 32'h00000000};
        for (int i = 0; i < 15; i++) begin
            logic [TAG_W-1:0]  t;
            logic [NAME_W-1:0] n;
            t = TAG_W'(i + 1);
            n = NAME_W'(i + 8);
            drive_op(ops[i], av[i], bv[i], t, n, pcv[i]);
            step();
            drive_idle();
            for (int k = 1; k < LAT; k++) begin
                checks++;
                if (enALUwrt !== 1'b0) begin
                    failures++;
                    $display("FAIL op%0d_early: en=%b want 0 before latency", i, enALUwrt);
                end
                step();
            end
            checks++;
            if (enALUwrt !== 1'b1 || ALUtag !== t || ALUname !== n || ALUdata !== ev[i]) begin
                failures++;
                $display("FAIL op%0d_result: en=%b tag=%h name=%h data=%h, want 1/%h/%h/%h",
                         i, enALUwrt, ALUtag, ALUname, ALUdata, t, n, ev[i]);
            end
            step();
            checks++;
            if (enALUwrt !== 1'b0 || ALUtag !== TAG_FREE || ALUname !== NAME_FREE || ALUdata !== DATA_FREE) begin
                failures++;
                $display("FAIL op%0d_idle_after: en=%b tag=%h name=%h data=%h, want free values",
                         i, enALUwrt, ALUtag, ALUname, ALUdata);
            end
        end
    endtask

    task automatic test_nop();
        int seen = 0;
        drive_op(OP_NOP, 32'h1, 32'h1, 5'd9, 5'd9, 32'h0);
        step();
        drive_op(OP_ADD, 32'h1, 32'h1, 5'd10, 5'd10, 32'h0);
        ALUworkEn = 1'b0;
        step();
        drive_idle();
        for (int k = 0; k < LAT + 1; k++) begin
            if (enALUwrt === 1'b1) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL nop_no_broadcast: broadcasts=%0d want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        // Per-edge expectation: A=tag3/data2, B=tag4/data4, C=tag5/data6; rdy low on edges 3,4.
`ifdef ALU_PIPE2_EN
        logic [TAG_W-1:0] et [7] = '{5'd0, 5'd3, 5'd3, 5'd3, 5'd4, 5'd5, 5'd0};
`else
        logic [TAG_W-1:0] et [7] = '{5'd3, 5'd4, 5'd4, 5'd4, 5'd5, 5'd0, 5'd0};
`endif
        for (int e = 0; e < 7; e++) begin
            logic [31:0] ed;
            rdy = 1'b1;
            case (e)
                0: drive_op(OP_ADD, 32'h1, 32'h1, 5'd3, 5'd3, 32'h0);
                1: drive_op(OP_ADD, 32'h2, 32'h2, 5'd4, 5'd4, 32'h0);
                2, 3: begin
                    drive_op(OP_ADD, 32'h3, 32'h3, 5'd5, 5'd5, 32'h0);
                    rdy = 1'b0;
                end
                4: drive_op(OP_ADD, 32'h3, 32'h3, 5'd5, 5'd5, 32'h0);
                default: drive_idle();
            endcase
            step();
            ed = (et[e] == 5'd0) ? 32'h0 : 32'(2 * (et[e] - 5'd2));
            checks++;
            if (enALUwrt !== (et[e] != 5'd0) || ALUtag !== et[e] || ALUname !== et[e] || ALUdata !== ed) begin
                failures++;
                $display("FAIL b2b_edge%0d: en=%b tag=%h name=%h data=%h, want %b/%h/%h/%h",
                         e, enALUwrt, ALUtag, ALUname, ALUdata, (et[e] != 5'd0), et[e], et[e], ed);
            end
        end
        rdy = 1'b1;
        drive_idle();
    endtask

    task automatic test_async_reset();
        int seen = 0;
        drive_op(OP_ADD, 32'h10, 32'h20, 5'd7, 5'd7, 32'h0);
        step();
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (enALUwrt !== 1'b0 || ALUtag !== TAG_FREE || ALUname !== NAME_FREE || ALUdata !== DATA_FREE) begin
            failures++;
            $display("FAIL async_reset_immediate: en=%b tag=%h name=%h data=%h, want free values",
                     enALUwrt, ALUtag, ALUname, ALUdata);
        end
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (enALUwrt === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL async_reset_discard: broadcasts=%0d want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_nop();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_ex.md
ALU_EX -- requirements
Module: alu_ex

Interface
REQ-001 Parameter LINK_OFFSET, default 4, SHALL be the value added to instAddr for the link result of JAL/JALR.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rdy  input  1  global ready; when low, all state SHALL hold.
REQ-005 ALUworkEn  input  1  issue strobe from ALU reservation station.
REQ-006 operandO, operandT  input  32 each (DataBus)  source operands; for immediate ops, operandT carries the immediate.
REQ-007 opCode  input  OpBus  operation; NOP means no work.
REQ-008 wrtTag  input  TagBus  destination tag (ALU prefix + RS line index).
REQ-009 wrtName  input  NameBus  destination register name.
REQ-010 instAddr  input  32 (InstAddrBus)  instruction PC.
REQ-011 enALUwrt  output  1  result broadcast valid, to all reservation stations and register file.
REQ-012 ALUtag  output  TagBus  broadcast tag.
REQ-013 ALUdata  output  32  broadcast result.
REQ-014 ALUname  output  NameBus  broadcast destination name.

Function
REQ-015 An operation SHALL be accepted in every cycle with rdy=1, ALUworkEn=1 and opCode!=NOP; there is no backpressure, and the block SHALL never drop an accepted operation.
REQ-016 Ops: ADD/SUB/AND/OR/XOR = 32-bit wrap-around arithmetic/logic on operandO, operandT; SLL/SRL/SRA shift operandO by operandT[4:0]; SLT signed, SLTU unsigned compare giving 0 or 1; LUI = operandT; AUIPC = instAddr+operandT; JAL/JALR = instAddr+LINK_OFFSET.
REQ-017 Unknown opCode SHALL broadcast with ALUdata=0 (tag still released, no hang).
REQ-018 Default latency SHALL be 1 cycle: operation accepted at edge N produces enALUwrt=1 with its tag, name and data during cycle N+1 (registered outputs).
REQ-019 In any cycle with no accepted operation at the prior stage, enALUwrt SHALL be 0, ALUtag=tagFree, ALUname=nameFree, ALUdata=0.
REQ-020 Back-to-back operations SHALL produce back-to-back broadcasts in issue order, one per cycle.
REQ-021 rdy low mid-operation SHALL freeze all pipeline registers and outputs unchanged; resumption continues with no loss or duplication.
REQ-022 ALUworkEn=1 with opCode=NOP SHALL be treated as no operation.

Reset
REQ-023 rst SHALL asynchronously clear all valid bits and drive enALUwrt=0, ALUtag=tagFree, ALUdata=dataFree, ALUname=nameFree.
REQ-024 Operations in flight at reset SHALL be discarded, never broadcast.

Configuration
REQ-025 Macro ALU_PIPE2_EN defined: a second register stage SHALL be inserted between computation and broadcast, latency 2 cycles, throughput still 1 per cycle, two operations in flight at most.
REQ-026 ALU_PIPE2_EN undefined: single stage, latency 1 cycle as in REQ-018.

Structure
REQ-027 Opcode encodings, tagFree, nameFree, dataFree, DataBus/TagBus/NameBus/OpBus widths SHALL come from the shared defines package; no local redefinition.
REQ-028 One sub-module, alu_core, SHALL hold the purely combinational op datapath; alu_ex holds valid/stage registers and rdy/reset control.

Verification
REQ-029 ADD operandO=0xFFFFFFFF, operandT=2, tag T1 -> next cycle enALUwrt=1, ALUtag=T1, ALUdata=0x00000001.
REQ-030 SRA operandO=0x80000000, operandT=0x24 -> ALUdata=0xF8000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0.
REQ-031 JAL instAddr=0x1000 -> ALUdata=0x1004; AUIPC instAddr=0x1000, operandT=0x2000 -> 0x3000.
REQ-032 Three ops issued on consecutive cycles, rdy dropped for 2 cycles after the second -> three broadcasts in order, outputs frozen during rdy=0, none lost or duplicated.
REQ-033 rst asserted asynchronously with one op in flight -> outputs immediately enALUwrt=0, ALUtag=tagFree; no broadcast after release.
REQ-034 Same sequences with ALU_PIPE2_EN defined -> identical results, each delayed exactly one additional cycle.
